// File: rtl/mem_if.sv
// Load/store bus between the core and pipelined_mem: request, strobes,
// and the ready/valid/error response.
interface mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      mem_read_ctrl;
    logic                      mem_write_ctrl;
    logic [ADDR_WIDTH-1:0]     mem_address;
    logic [DATA_WIDTH-1:0]     mem_data_write;
    logic [DATA_WIDTH/8-1:0]   mem_byte_en;
    logic [DATA_WIDTH-1:0]     mem_data_read;
    logic                      mem_ready;
    logic                      mem_valid;
    logic                      mem_error;

    modport master (
        output mem_read_ctrl, mem_write_ctrl, mem_address,
        output mem_data_write, mem_byte_en,
        input  mem_data_read, mem_ready, mem_valid, mem_error
    );

    modport slave (
        input  mem_read_ctrl, mem_write_ctrl, mem_address,
        input  mem_data_write, mem_byte_en,
        output mem_data_read, mem_ready, mem_valid, mem_error
    );
endinterface

// File: rtl/pipelined_mem.sv
// Word-addressed memory with byte strobes and configurable read latency.
// Define MEM_RANGE_CHECK_EN to flag out-of-range or misaligned accesses.
module pipelined_mem #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int                    READ_LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFB  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD =
        4'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_pend;
    logic                  r_pend_bad;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid;
    logic                  r_error;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDXW-1:0]       w_index;
    logic                  w_bad;
    logic                  w_ready;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_out_word;
    logic                  w_out_bad;
    logic                  w_unused;

    assign w_offset = bus.mem_address - BASE_ADDRESS;
    assign w_word   = w_offset >> OFFB;
    assign w_index  = w_word[IDXW-1:0];
    assign w_unused = ^w_word;

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(BYTES - 1);
    // Address below base wraps to a huge offset, so one compare covers both ends
    assign w_bad = (w_offset >= LIMIT) || ((w_offset & AMASK) != '0);
`else
    assign w_bad = 1'b0;
`endif

    assign w_ready = (r_state == IDLE);
    assign w_wr    = w_ready & bus.mem_write_ctrl;
    assign w_rd    = w_ready & bus.mem_read_ctrl & ~bus.mem_write_ctrl;

    assign w_rd_word  = w_bad ? '0 : r_mem[w_index];
    assign w_out_word = (READ_LATENCY == 1) ? w_rd_word : r_pend;
    assign w_out_bad  = (READ_LATENCY == 1) ? w_bad : r_pend_bad;
    assign w_done     = (READ_LATENCY == 1) ? w_rd
                      : (r_state == RD_WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_rd && READ_LATENCY > 1) w_next = RD_WAIT;
            RD_WAIT: if (r_cnt == 4'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_pend     <= '0;
            r_pend_bad <= 1'b0;
            r_rdata    <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_done;
            r_error <= (w_wr & w_bad) | (w_done & w_out_bad);
            if (w_rd) begin
                r_cnt      <= CNT_LOAD;
                r_pend     <= w_rd_word;
                r_pend_bad <= w_bad;
            end else if (r_state == RD_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done) r_rdata <= w_out_bad ? '0 : w_out_word;
        end
    end

    // Storage is deliberately outside reset so contents survive it
    always_ff @(posedge clk) begin
        if (!rst && w_wr && !w_bad) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.mem_byte_en[i])
                    r_mem[w_index][8*i +: 8] <= bus.mem_data_write[8*i +: 8];
            end
        end
    end

    assign bus.mem_ready     = w_ready;
    assign bus.mem_valid     = r_valid;
    assign bus.mem_error     = r_error;
    assign bus.mem_data_read = r_rdata;
endmodule

// File: tb/tb_pipelined_mem.sv
// Directed bench for pipelined_mem at read latencies 1, 2 and 4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pipelined_mem;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
    mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b2 ();
    mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b4 ();

    pipelined_mem #(.READ_LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b1));
    pipelined_mem #(.READ_LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b2));
    pipelined_mem #(.READ_LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        b2.mem_write_ctrl = 1'b1;
        b2.mem_address    = a;
        b2.mem_data_write = d;
        b2.mem_byte_en    = be;
        tick();
        b2.mem_write_ctrl = 1'b0;
    endtask

    // Returns sampled in cycle N+1, where L=2 data is valid
    task automatic rd2(input logic [31:0] a);
        b2.mem_read_ctrl = 1'b1;
        b2.mem_address   = a;
        tick();
        b2.mem_read_ctrl = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        b1.mem_read_ctrl = 0; b1.mem_write_ctrl = 0; b1.mem_address = 0;
        b1.mem_data_write = 0; b1.mem_byte_en = 4'hF;
        b2.mem_read_ctrl = 0; b2.mem_write_ctrl = 0; b2.mem_address = 0;
        b2.mem_data_write = 0; b2.mem_byte_en = 4'hF;
        b4.mem_read_ctrl = 0; b4.mem_write_ctrl = 0; b4.mem_address = 0;
        b4.mem_data_write = 0; b4.mem_byte_en = 4'hF;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(b2.mem_ready), 32'd1);
        chk("rst_valid", 32'(b2.mem_valid), 32'd0);
        chk("rst_error", 32'(b2.mem_error), 32'd0);
        chk("rst_data",  b2.mem_data_read,  32'd0);
        chk("rst_data_l1", b1.mem_data_read, 32'd0);
        chk("rst_data_l4", b4.mem_data_read, 32'd0);

        // L=2 write then read
        wr2(32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_ready", 32'(b2.mem_ready), 32'd1);
        chk("wr_novalid", 32'(b2.mem_valid), 32'd0);
        b2.mem_read_ctrl = 1'b1;
        b2.mem_address   = 32'h10;
        tick();
        b2.mem_read_ctrl = 1'b0;
        chk("rd_n_ready", 32'(b2.mem_ready), 32'd0);
        chk("rd_n_valid", 32'(b2.mem_valid), 32'd0);
        tick();
        chk("rd_n1_valid", 32'(b2.mem_valid), 32'd1);
        chk("rd_n1_ready", 32'(b2.mem_ready), 32'd1);
        chk("rd_n1_data", b2.mem_data_read, 32'hDEADBEEF);
        tick();
        chk("rd_pulse_end", 32'(b2.mem_valid), 32'd0);
        chk("rd_data_hold", b2.mem_data_read, 32'hDEADBEEF);

        // byte strobes
        wr2(32'h20, 32'h11223344, 4'hF);
        wr2(32'h20, 32'hAABBCCDD, 4'b0101);
        rd2(32'h20);
        chk("strobe_valid", 32'(b2.mem_valid), 32'd1);
        chk("strobe_data", b2.mem_data_read, 32'h11BB33DD);

        // read+write together: write wins, no valid
        b2.mem_read_ctrl = 1'b1;
        wr2(32'h30, 32'h5, 4'hF);
        b2.mem_read_ctrl = 1'b0;
        chk("rw_ready", 32'(b2.mem_ready), 32'd1);
        chk("rw_novalid0", 32'(b2.mem_valid), 32'd0);
        tick();
        chk("rw_novalid1", 32'(b2.mem_valid), 32'd0);
        rd2(32'h30);
        chk("rw_data", b2.mem_data_read, 32'h5);

        wr2(32'h0, 32'hCAFE0000, 4'hF);
`ifdef MEM_RANGE_CHECK_EN
        wr2(32'h400, 32'h00000BAD, 4'hF);
        chk("bad_wr_err", 32'(b2.mem_error), 32'd1);
        tick();
        chk("bad_wr_err_end", 32'(b2.mem_error), 32'd0);
        rd2(32'h0);
        chk("bad_wr_unchanged", b2.mem_data_read, 32'hCAFE0000);
        chk("good_rd_noerr", 32'(b2.mem_error), 32'd0);
        b2.mem_read_ctrl = 1'b1;
        b2.mem_address   = 32'h6;
        tick();
        b2.mem_read_ctrl = 1'b0;
        chk("bad_rd_err_n", 32'(b2.mem_error), 32'd0);
        tick();
        chk("bad_rd_valid", 32'(b2.mem_valid), 32'd1);
        chk("bad_rd_err", 32'(b2.mem_error), 32'd1);
        chk("bad_rd_data", b2.mem_data_read, 32'd0);
`else
        rd2(32'h400);
        chk("wrap_valid", 32'(b2.mem_valid), 32'd1);
        chk("wrap_data", b2.mem_data_read, 32'hCAFE0000);
        chk("wrap_noerr", 32'(b2.mem_error), 32'd0);
`endif

        // L=1 back-to-back reads
        for (int i = 0; i < 3; i++) begin
            b1.mem_write_ctrl = 1'b1;
            b1.mem_address    = 32'(4 * i);
            b1.mem_data_write = 32'hA0000000 + 32'(i);
            tick();
        end
        b1.mem_write_ctrl = 1'b0;
        b1.mem_read_ctrl  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b1.mem_address = 32'(4 * i);
            tick();
            chk("l1_valid", 32'(b1.mem_valid), 32'd1);
            chk("l1_ready", 32'(b1.mem_ready), 32'd1);
            chk("l1_data", b1.mem_data_read, 32'hA0000000 + 32'(i));
        end
        b1.mem_read_ctrl = 1'b0;
        tick();
        chk("l1_idle_valid", 32'(b1.mem_valid), 32'd0);

        // L=4 read abandoned by reset
        b4.mem_write_ctrl = 1'b1;
        b4.mem_address    = 32'h10;
        b4.mem_data_write = 32'h12345678;
        tick();
        b4.mem_write_ctrl = 1'b0;
        b4.mem_read_ctrl  = 1'b1;
        tick();
        b4.mem_read_ctrl = 1'b0;
        chk("l4_n_ready", 32'(b4.mem_ready), 32'd0);
        tick();
        chk("l4_n1_ready", 32'(b4.mem_ready), 32'd0);
        chk("l4_n1_valid", 32'(b4.mem_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("l4_rst_ready", 32'(b4.mem_ready), 32'd1);
        chk("l4_rst_valid", 32'(b4.mem_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("l4_abandoned", 32'(b4.mem_valid), 32'd0);
        end
        b4.mem_read_ctrl = 1'b1;
        tick();
        b4.mem_read_ctrl = 1'b0;
        tick();
        tick();
        chk("l4_n2_valid", 32'(b4.mem_valid), 32'd0);
        tick();
        chk("l4_valid", 32'(b4.mem_valid), 32'd1);
        chk("l4_data", b4.mem_data_read, 32'h12345678);
        chk("l4_ready", 32'(b4.mem_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_mem.md
# pipelined_mem

Parametrised word-addressed data/instruction memory model that serves the processor's load/store port. It extends the basic single-cycle memory with configurable data width, depth, base address and read latency. It adds per-byte write enables and a ready/valid handshake so the core can be run against slow memory. Optional range checking flags bad accesses. It sits directly on the processor's memory bus and is instantiated beside the core in system benches.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 256, number of words; power of two.
- BASE_ADDRESS, 32'h0, byte address of word 0.
- READ_LATENCY, 2, cycles from the accepting edge to data valid; legal range 1..8.
- Reset is synchronous and active-high: all state changes below occur on the rising edge of clk when rst=1. Clock port is clk; reset port is rst.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous active-high reset.
- mem_read_ctrl  input  1  read request.
- mem_write_ctrl  input  1  write request.
- mem_address  input  ADDR_WIDTH  byte address.
- mem_data_write  input  DATA_WIDTH  write data.
- mem_byte_en  input  DATA_WIDTH/8  per-byte write strobe; lane i covers bits 8i+7:8i.
- mem_data_read  output  DATA_WIDTH  read data; holds its value between valids.
- mem_ready  output  1  request can be accepted this cycle.
- mem_valid  output  1  one-cycle pulse; mem_data_read is valid.
- mem_error  output  1  one-cycle pulse on a bad access.

## Operation
- Word index = (mem_address − BASE_ADDRESS) >> log2(DATA_WIDTH/8).
- A request is accepted at an edge where mem_ready=1 and either ctrl=1.
- Write accepted: each byte lane with mem_byte_en=1 is updated at the accepting edge. Lanes with strobe 0 keep their value. mem_ready stays 1. No mem_valid is produced.
- Read and write both asserted: the write is performed and the read is dropped. No mem_valid is produced.
- FSM states:
  - IDLE: mem_ready=1.
  - RD_WAIT: mem_ready=0; the down-counter loads READ_LATENCY−2 when a read is accepted and READ_LATENCY>1.
  - RD_WAIT exits to IDLE when the counter reaches 0, with data valid.
- Reset: FSM→IDLE, counter=0, mem_ready=1, mem_valid=0, mem_error=0, mem_data_read=0.
- Reset does not clear memory contents.
- Reset during RD_WAIT abandons the read; no mem_valid is produced for it.
- Requests presented while mem_ready=0 are ignored, not queued.

## Timing
- Let N be the accepting edge; cycle k is the interval after edge k.
- Read with L=READ_LATENCY:
  - Cycles N..N+L−2: mem_ready=0, mem_valid=0.
  - Cycle N+L−1: mem_valid=1, mem_ready=1, mem_data_read = the word as it was before edge N.
  - A new request may be accepted at edge N+L.
- L=1: mem_ready never drops; back-to-back reads give one valid per cycle.
- A write at edge N followed by a read of the same word at edge N+1 returns the new data.
- mem_data_read changes only at the edge that raises mem_valid, or at reset.

## Configuration
- MEM_RANGE_CHECK_EN defined:
  - A bad access is one whose address lies outside [BASE_ADDRESS, BASE_ADDRESS+DEPTH·DATA_WIDTH/8), or whose low log2(DATA_WIDTH/8) bits are nonzero.
  - Bad write: suppressed; mem_error=1 in cycle N.
  - Bad read: handshake runs normally; mem_data_read=0 and mem_error=1 in the same cycle as mem_valid.
- MEM_RANGE_CHECK_EN undefined:
  - Low address bits are ignored.
  - The word index wraps modulo DEPTH.
  - mem_error is tied to 0.

## Test plan
- Reset, then idle: mem_ready=1, mem_valid=0, mem_data_read=0. Then write 32'hDEADBEEF to 0x10 with strobe 4'hF, and read 0x10 with L=2. Required: valid in cycle N+1 with data DEADBEEF, mem_ready=0 in cycle N only.
- Write 32'h11223344 to 0x20, then write 32'hAABBCCDD to 0x20 with strobe 4'b0101 -> a read returns 32'h11BB33DD.
- L=1: reads of 0x0, 0x4, 0x8 on three consecutive edges -> three consecutive valid cycles with matching data; mem_ready stays 1.
- L=4: read accepted at edge 10, rst=1 sampled at edge 12 -> no mem_valid at all; mem_ready=1 from cycle 12. A subsequent read returns the previously written data.
- Read and write both asserted to 0x30 with data 32'h5 -> 0x30 holds 5, no mem_valid pulse.
- With MEM_RANGE_CHECK_EN, DEPTH=256:
  - Write to 0x400 -> mem_error pulse and memory unchanged.
  - Read from 0x6 -> mem_valid and mem_error in the same cycle, data 0.
- Without MEM_RANGE_CHECK_EN, DEPTH=256: a read of 0x400 returns word 0.
